pmpregionenc: RTL

//  Encoder side of the PMP address-match scheme: turns a region request (base, inclusive last address, permissions, entry index)

---
 rtl/pmpregionenc_if.sv | 40 ++++
 rtl/pmpregionenc.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pmpregionenc_if.sv
// ---------------------------------------------------------------------------
// pmpregionenc_if : region-request and CSR-write bundle for pmpregionenc
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pmpregionenc_if #(
  parameter int PA_BITS     = 56,
  parameter int PMP_ENTRIES = 16
);
  localparam int IW = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1;

  logic                   ReqValid;
  logic                   ReqReady;
  logic [PA_BITS-1:0]     ReqBase;
  logic [PA_BITS-1:0]     ReqLast;
  logic [IW-1:0]          ReqIdx;
  logic [3:0]             ReqPerm;
  logic [PMP_ENTRIES-1:0] CfgLockIn;
  logic                   CSRWrValid;
  logic                   CSRWrReady;
  logic                   CSRWrIsCfg;
  logic [IW-1:0]          CSRWrIdx;
  logic [PA_BITS-3:0]     CSRWrData;
  logic                   Done;
  logic                   Err;
  logic [1:0]             Mode;

  modport slave (
    input  ReqValid, ReqBase, ReqLast, ReqIdx, ReqPerm, CfgLockIn, CSRWrReady,
    output ReqReady, CSRWrValid, CSRWrIsCfg, CSRWrIdx, CSRWrData, Done, Err, Mode
  );

  modport master (
    output ReqValid, ReqBase, ReqLast, ReqIdx, ReqPerm, CfgLockIn, CSRWrReady,
    input  ReqReady, CSRWrValid, CSRWrIsCfg, CSRWrIdx, CSRWrData, Done, Err, Mode
  );
endinterface

`default_nettype wire

// File: rtl/pmpregionenc.sv
// ---------------------------------------------------------------------------
// pmpregionenc : encodes a region request into PMP addr/cfg CSR writes
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pmpregionenc #(
  parameter int PA_BITS     = 56,
  parameter int PMP_ENTRIES = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  pmpregionenc_if.slave bus
);
  localparam int IW = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1;
  localparam int AW = PA_BITS - 2;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_TOR   = 2'b01;
  localparam logic [1:0] MODE_NA4   = 2'b10;
  localparam logic [1:0] MODE_NAPOT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_WR_PCFG = 3'd2,
    S_WR_PADR = 3'd3,
    S_WR_ADR  = 3'd4,
    S_WR_CFG  = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [PA_BITS-1:0]     base_q, last_q;
  logic [IW-1:0]          idx_q;
  logic [3:0]             perm_q;
  logic [PMP_ENTRIES-1:0] lock_q;
  logic [AW-1:0]          addr_q, addr_d;
  logic [1:0]             mode_q, mode_d;
  logic                   err_q, err_d;
  logic                   lower_q, lower_d;

  logic [PA_BITS:0]       size_w, size_m1_w;
  logic                   fmt_err_w, pow2_w, na4_w, napot_w;
  logic [IW-1:0]          lower_idx_w;
  logic [7:0]             cfg_byte_w;

  assign lower_idx_w = idx_q - IW'(1);
  assign cfg_byte_w  = {perm_q[3], 2'b00, mode_q, perm_q[2:0]};

  // Region classification; S is one bit wider so the whole-space region fits.
  always_comb begin
    size_w    = {1'b0, last_q} - {1'b0, base_q} + (PA_BITS+1)'(1);
    size_m1_w = {1'b0, last_q} - {1'b0, base_q};
    fmt_err_w = (base_q[1:0] != 2'b00) || (last_q[1:0] != 2'b11) || (last_q < base_q);
    pow2_w    = (size_w != '0) && ((size_w & size_m1_w) == '0);
    na4_w     = (size_w == (PA_BITS+1)'(4));
    napot_w   = !na4_w && pow2_w && (size_w >= (PA_BITS+1)'(8)) &&
                (({1'b0, base_q} & size_m1_w) == '0);

    err_d   = 1'b0;
    lower_d = 1'b0;
    mode_d  = MODE_OFF;
    addr_d  = '0;
    if (fmt_err_w) begin
      err_d = 1'b1;
    end else if (na4_w) begin
      mode_d = MODE_NA4;
      addr_d = base_q[PA_BITS-1:2];
    end else if (napot_w) begin
      mode_d = MODE_NAPOT;
      addr_d = base_q[PA_BITS-1:2] | (size_w[PA_BITS:3] - AW'(1));
    end else begin
      mode_d  = MODE_TOR;
      lower_d = (idx_q != '0);
      // last[1:0] is 11 here, so (last+1)>>2 equals last[PA_BITS-1:2]+1
      addr_d  = last_q[PA_BITS-1:2] + AW'(1);
      if ((&last_q) || ((idx_q == '0) && (base_q != '0)))
        err_d = 1'b1;
      if (lower_d && lock_q[lower_idx_w])
        err_d = 1'b1;
    end
    if (lock_q[idx_q])
      err_d = 1'b1;
    if (err_d) begin
      mode_d  = MODE_OFF;
      lower_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      perm_q  <= '0;
      lock_q  <= '0;
      addr_q  <= '0;
      mode_q  <= MODE_OFF;
      err_q   <= 1'b0;
      lower_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && bus.ReqValid) begin
        base_q <= bus.ReqBase;
        last_q <= bus.ReqLast;
        idx_q  <= bus.ReqIdx;
        perm_q <= bus.ReqPerm;
        lock_q <= bus.CfgLockIn;
      end
      if (state_q == S_CHECK) begin
        addr_q  <= addr_d;
        mode_q  <= mode_d;
        err_q   <= err_d;
        lower_q <= lower_d;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    bus.ReqReady    = 1'b0;
    bus.CSRWrValid  = 1'b0;
    bus.CSRWrIsCfg  = 1'b0;
    bus.CSRWrIdx    = '0;
    bus.CSRWrData   = '0;
    bus.Done        = 1'b0;
    bus.Err         = 1'b0;
    bus.Mode        = MODE_OFF;
    unique case (state_q)
      S_IDLE: begin
        bus.ReqReady = 1'b1;
        if (bus.ReqValid) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (err_d)        state_d = S_DONE;
        else if (lower_d) state_d = S_WR_PCFG;
        else              state_d = S_WR_ADR;
      end
      // Lower entry is switched OFF first so no intermediate state matches wider.
      S_WR_PCFG: begin
        bus.CSRWrValid = 1'b1;
        bus.CSRWrIsCfg = 1'b1;
        bus.CSRWrIdx   = lower_idx_w;
        if (bus.CSRWrReady) state_d = S_WR_PADR;
      end
      S_WR_PADR: begin
        bus.CSRWrValid = 1'b1;
        bus.CSRWrIdx   = lower_idx_w;
        bus.CSRWrData  = base_q[PA_BITS-1:2];
        if (bus.CSRWrReady) state_d = S_WR_ADR;
      end
      S_WR_ADR: begin
        bus.CSRWrValid = 1'b1;
        bus.CSRWrIdx   = idx_q;
        bus.CSRWrData  = addr_q;
        if (bus.CSRWrReady) state_d = S_WR_CFG;
      end
      S_WR_CFG: begin
        bus.CSRWrValid = 1'b1;
        bus.CSRWrIsCfg = 1'b1;
        bus.CSRWrIdx   = idx_q;
        bus.CSRWrData  = {{(AW-8){1'b0}}, cfg_byte_w};
        if (bus.CSRWrReady) state_d = S_DONE;
      end
      S_DONE: begin
        bus.Done = 1'b1;
        bus.Err  = err_q;
        bus.Mode = mode_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

`default_nettype wire
